// File: rtl/ir_decode_seq.sv
// ir_decode_seq: sequence counter, phase tracker and instruction decoder for
// the Mano CPU. Sits downstream of the instruction register (REG_IR loads at
// t==1) and supplies timing and decoded instruction fields to the control unit.
//
// Ports:
//   CLK, RST_N   clock (rising edge), asynchronous active-low reset
//   START        single-cycle pulse, enters the run state when idle
//   CLR_SC       execution complete, clears the sequence counter
//   Q_IR         instruction register contents (bits [15:0] decoded)
//   t            sequence counter value
//   T            one-hot decode of t, all zeros when not running
//   PHASE        0=IDLE 1=FETCH 2=DECODE 3=EXEC
//   D, I_BIT, B  registered opcode one-hot, indirect bit, address field
//   MEM_REF, REG_REF, IO_REF  instruction class, derived from D/I_BIT
//   RUN          run state
//   SC_ERR       sticky: counter wrapped without CLR_SC
//   INSTR_CNT    completed-instruction count (only with IR_DECODE_INSTR_CNT_EN)
//
// Optional feature macro: IR_DECODE_INSTR_CNT_EN adds the INSTR_CNT output.

module ir_decode_seq #(
    parameter int unsigned SC_W = 3,
    parameter int unsigned IR_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  CLR_SC,
    input  logic [IR_W-1:0]       Q_IR,
    output logic [SC_W-1:0]       t,
    output logic [(1<<SC_W)-1:0]  T,
    output logic [1:0]            PHASE,
    output logic [7:0]            D,
    output logic                  I_BIT,
    output logic [11:0]           B,
    output logic                  MEM_REF,
    output logic                  REG_REF,
    output logic                  IO_REF,
    output logic                  RUN,
    output logic                  SC_ERR
`ifdef IR_DECODE_INSTR_CNT_EN
    ,
    output logic [15:0]           INSTR_CNT
`endif
);

    localparam int unsigned T_W = 1 << SC_W;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_FETCH  = 2'd1,
        PH_DECODE = 2'd2,
        PH_EXEC   = 2'd3
    } phase_t;

    phase_t          ph_q, ph_n;
    logic            run_q, run_n;
    logic [SC_W-1:0] sc_q, sc_n;
    logic [T_W-1:0]  oh_q, oh_n;
    logic            err_q, err_n;
    logic [7:0]      d_q, d_n;
    logic            ib_q, ib_n;
    logic [11:0]     b_q, b_n;
    logic            hlt;
`ifdef IR_DECODE_INSTR_CNT_EN
    logic [15:0]     cnt_q, cnt_n;
`endif

    // HLT is a register-reference instruction with B[0] set, acted on at t==3
    assign hlt = run_q && (sc_q == SC_W'(3)) && d_q[7] && !ib_q && b_q[0];

    // Next-state logic for counter, run state, phase and decoded fields
    always_comb begin
        run_n = run_q;
        sc_n  = sc_q;
        err_n = err_q;
        d_n   = d_q;
        ib_n  = ib_q;
        b_n   = b_q;
        ph_n  = PH_IDLE;
        oh_n  = '0;
`ifdef IR_DECODE_INSTR_CNT_EN
        cnt_n = cnt_q;
`endif

        if (!run_q) begin
            if (START) begin
                run_n = 1'b1;
                sc_n  = '0;
            end
        end else if (hlt) begin
            // HLT wins over a simultaneous CLR_SC; the end state is the same
            run_n = 1'b0;
            sc_n  = '0;
`ifdef IR_DECODE_INSTR_CNT_EN
            cnt_n = cnt_q + 16'd1;
`endif
        end else if (CLR_SC) begin
            sc_n  = '0;
`ifdef IR_DECODE_INSTR_CNT_EN
            cnt_n = cnt_q + 16'd1;
`endif
        end else if (sc_q == SC_W'(T_W - 1)) begin
            // Runaway instruction: wrap into a fresh fetch and flag it
            sc_n  = '0;
            err_n = 1'b1;
        end else begin
            sc_n  = sc_q + SC_W'(1);
        end

        // IR was loaded at the t==1 edge, so it is stable at the t==2 edge
        if (run_q && (sc_q == SC_W'(2))) begin
            d_n  = 8'(1) << Q_IR[14:12];
            ib_n = Q_IR[15];
            b_n  = Q_IR[11:0];
        end

        if (run_n) begin
            oh_n = T_W'(1) << sc_n;
            if (sc_n <= SC_W'(1)) begin
                ph_n = PH_FETCH;
            end else if (sc_n == SC_W'(2)) begin
                ph_n = PH_DECODE;
            end else begin
                ph_n = PH_EXEC;
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph_q  <= PH_IDLE;
            run_q <= 1'b0;
            sc_q  <= '0;
            oh_q  <= '0;
            err_q <= 1'b0;
            d_q   <= '0;
            ib_q  <= 1'b0;
            b_q   <= '0;
`ifdef IR_DECODE_INSTR_CNT_EN
            cnt_q <= '0;
`endif
        end else begin
            ph_q  <= ph_n;
            run_q <= run_n;
            sc_q  <= sc_n;
            oh_q  <= oh_n;
            err_q <= err_n;
            d_q   <= d_n;
            ib_q  <= ib_n;
            b_q   <= b_n;
`ifdef IR_DECODE_INSTR_CNT_EN
            cnt_q <= cnt_n;
`endif
        end
    end

    assign t      = sc_q;
    assign T      = oh_q;
    assign PHASE  = ph_q;
    assign RUN    = run_q;
    assign SC_ERR = err_q;
    assign D      = d_q;
    assign I_BIT  = ib_q;
    assign B      = b_q;

    // D is all zeros only before the first capture, so gating on |D keeps
    // every class strobe low out of reset
    assign MEM_REF = (|d_q) & ~d_q[7];
    assign REG_REF = d_q[7] & ~ib_q;
    assign IO_REF  = d_q[7] & ib_q;

`ifdef IR_DECODE_INSTR_CNT_EN
    assign INSTR_CNT = cnt_q;
`endif

endmodule

// File: doc/ir_decode_seq.md
Name: ir_decode_seq

Overview:
Sequence counter and instruction decoder for the Mano CPU. It sits directly downstream of the instruction register.
- Generates the timing count `t` that REG_IR uses to load at t==1.
- Decodes the loaded IR word into opcode, addressing-mode and class strobes for the control unit.
- Owns the run/halt state and the fetch/decode/execute phase tracking.

Parameters:
- SC_W, 3, sequence counter width; the count wraps at 2**SC_W-1.
- IR_W, 16, instruction width; must be at least 16. Only bits [15:0] are decoded.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle pulse; sets the run state.
- CLR_SC  in  1  execution complete; synchronously clears SC.
- Q_IR  in  IR_W  instruction register contents.
- t  out  SC_W  sequence counter value; drives the REG_IR `t` input.
- T  out  2**SC_W  one-hot decode of t. All zeros when not running.
- PHASE  out  2  0=IDLE, 1=FETCH, 2=DECODE, 3=EXEC.
- D  out  8  one-hot decode of opcode Q_IR[14:12], registered.
- I_BIT  out  1  Q_IR[15], registered.
- B  out  12  Q_IR[11:0], registered.
- MEM_REF  out  1  D[7]==0.
- REG_REF  out  1  D[7] & ~I_BIT.
- IO_REF  out  1  D[7] & I_BIT.
- RUN  out  1  run state.
- SC_ERR  out  1  sticky flag: SC wrapped without CLR_SC.

Behaviour:
Reset:
- RST_N low clears every register asynchronously.
- All outputs read 0 and the FSM is in IDLE.
- Reset mid-instruction aborts immediately. No decode state is retained.

Run state:
- START while RUN=0 sets RUN on the next edge, with SC=0 and PHASE=FETCH.
- START while RUN=1 is ignored.

Sequence counter (RUN=1):
- Each edge: SC <= SC+1.
- CLR_SC=1 forces SC <= 0 and has priority over increment and over wrap.
- SC at 2**SC_W-1 with CLR_SC=0: SC wraps to 0, SC_ERR is set, and the wrap is treated as a new fetch.
- SC_ERR clears only on reset.

Phase FSM (RUN=1):
- FETCH while t is 0 or 1.
- DECODE while t==2.
- EXEC while t>=3.
- After CLR_SC, or on wrap: back to FETCH.
- RUN=0: IDLE, t held at 0, T all zeros.

Decode:
- On the rising edge where RUN=1 and t==2 (IR loaded at the t==1 edge), capture D, I_BIT and B from Q_IR.
- Decoded outputs are valid from t==3 and held until the next t==2 capture.
- MEM_REF, REG_REF and IO_REF are combinational from the registered fields.
- Q_IR changes at any other time have no effect.

Halt:
- At the edge with t==3, REG_REF=1 and B[0]=1 (HLT, 16'h7001): RUN <= 0, SC <= 0, PHASE <= IDLE.
- Registered D, I_BIT and B are held while halted.
- HLT takes priority over a simultaneous CLR_SC. The final state is identical either way.

Optional Feature:
- Macro: IR_DECODE_INSTR_CNT_EN.
- Defined: adds output INSTR_CNT (16 bits, reset 0).
  - Increments on each edge where RUN=1 and CLR_SC=1, and on the HLT edge.
  - Wraps 16'hFFFF to 0.
  - Not incremented on SC_ERR wrap.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then RST_N=1 with no START for 10 cycles → t=0, T=0, PHASE=0, RUN=0, D=0.
- START pulse, Q_IR=16'h5123 from the t==1 edge onward → t runs 0,1,2,3. From t==3: D=8'b0010_0000, I_BIT=0, B=12'h123, MEM_REF=1, PHASE=3.
- CLR_SC asserted at t==4 → next cycle t=0, PHASE=1. D stays 8'h20 until the following t==2 capture.
- Q_IR=16'h7001 captured at t==2 → at the t==3 edge: RUN=0, t=0, PHASE=0, REG_REF=1. Counter frozen until START; a later START resumes at t=0.
- Q_IR=16'hF800, running, no CLR_SC → IO_REF=1, I_BIT=1, D[7]=1. t wraps 7→0 with SC_ERR=1, which stays 1 after a later CLR_SC.
- Reset asserted at t==5 → all outputs 0 asynchronously, before the next clock edge. With IR_DECODE_INSTR_CNT_EN defined, three CLR_SC-terminated instructions give INSTR_CNT=3.
